// File: rtl/axi_modify_address_pkg.sv
// Channel and request/response types for the address-substituting AXI4 pass-through.
// Slave-side and master-side request types differ only in the width of their AW/AR address.
package axi_modify_address_pkg;

  localparam int unsigned SlvPortAddrWidth = 32;
  localparam int unsigned MstPortAddrWidth = 48;
  localparam int unsigned DataWidth        = 64;
  localparam int unsigned StrbWidth        = DataWidth / 8;
  localparam int unsigned IdWidth          = 3;
  localparam int unsigned UserWidth        = 2;

  typedef logic [IdWidth-1:0]          id_t;
  typedef logic [SlvPortAddrWidth-1:0] slv_addr_t;
  typedef logic [MstPortAddrWidth-1:0] mst_addr_t;
  typedef logic [DataWidth-1:0]        data_t;
  typedef logic [StrbWidth-1:0]        strb_t;
  typedef logic [UserWidth-1:0]        user_t;
  typedef logic [7:0]                  len_t;
  typedef logic [2:0]                  size_t;
  typedef logic [1:0]                  burst_t;
  typedef logic [3:0]                  cache_t;
  typedef logic [2:0]                  prot_t;
  typedef logic [3:0]                  qos_t;
  typedef logic [3:0]                  region_t;
  typedef logic [5:0]                  atop_t;
  typedef logic [1:0]                  resp_code_t;

  localparam burst_t     BURST_FIXED = 2'b00;
  localparam burst_t     BURST_INCR  = 2'b01;
  localparam burst_t     BURST_WRAP  = 2'b10;
  localparam resp_code_t RESP_OKAY   = 2'b00;
  localparam resp_code_t RESP_EXOKAY = 2'b01;
  localparam resp_code_t RESP_SLVERR = 2'b10;
  localparam resp_code_t RESP_DECERR = 2'b11;

  typedef struct packed {
    id_t       id;
    slv_addr_t addr;
    len_t      len;
    size_t     size;
    burst_t    burst;
    logic      lock;
    cache_t    cache;
    prot_t     prot;
    qos_t      qos;
    region_t   region;
    atop_t     atop;
    user_t     user;
  } aw_chan_slv_t;

  typedef struct packed {
    id_t       id;
    mst_addr_t addr;
    len_t      len;
    size_t     size;
    burst_t    burst;
    logic      lock;
    cache_t    cache;
    prot_t     prot;
    qos_t      qos;
    region_t   region;
    atop_t     atop;
    user_t     user;
  } aw_chan_mst_t;

  typedef struct packed {
    id_t       id;
    slv_addr_t addr;
    len_t      len;
    size_t     size;
    burst_t    burst;
    logic      lock;
    cache_t    cache;
    prot_t     prot;
    qos_t      qos;
    region_t   region;
    user_t     user;
  } ar_chan_slv_t;

  typedef struct packed {
    id_t       id;
    mst_addr_t addr;
    len_t      len;
    size_t     size;
    burst_t    burst;
    logic      lock;
    cache_t    cache;
    prot_t     prot;
    qos_t      qos;
    region_t   region;
    user_t     user;
  } ar_chan_mst_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    resp_code_t resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    resp_code_t resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_slv_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    ar_chan_slv_t ar;
    logic         ar_valid;
    logic         r_ready;
  } slv_req_t;

  typedef struct packed {
    aw_chan_mst_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    ar_chan_mst_t ar;
    logic         ar_valid;
    logic         r_ready;
  } mst_req_t;

  // Responses carry no address, so both ports share one type.
  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_modify_address.sv
// Zero-latency AXI4 pass-through that substitutes externally supplied AW/AR addresses.
// Stateless: reset only forces valids/readies low while asserted; payloads always flow.
module axi_modify_address
  import axi_modify_address_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  slv_req_t  slv_req_i,
  output resp_t     slv_resp_o,
  input  mst_addr_t mst_aw_addr_i,
  input  mst_addr_t mst_ar_addr_i,
  output mst_req_t  mst_req_o,
  input  resp_t     mst_resp_i
);

  logic hs_en;
  logic unused_inputs;

  assign hs_en = ~rst_i;

  // Upstream addresses are discarded; the address provider consumes them outside this block.
  assign unused_inputs = ^{clk_i, slv_req_i.aw.addr, slv_req_i.ar.addr};

  assign mst_req_o.aw.id     = slv_req_i.aw.id;
  assign mst_req_o.aw.addr   = mst_aw_addr_i;
  assign mst_req_o.aw.len    = slv_req_i.aw.len;
  assign mst_req_o.aw.size   = slv_req_i.aw.size;
  assign mst_req_o.aw.burst  = slv_req_i.aw.burst;
  assign mst_req_o.aw.lock   = slv_req_i.aw.lock;
  assign mst_req_o.aw.cache  = slv_req_i.aw.cache;
  assign mst_req_o.aw.prot   = slv_req_i.aw.prot;
  assign mst_req_o.aw.qos    = slv_req_i.aw.qos;
  assign mst_req_o.aw.region = slv_req_i.aw.region;
  assign mst_req_o.aw.atop   = slv_req_i.aw.atop;
  assign mst_req_o.aw.user   = slv_req_i.aw.user;
  assign mst_req_o.aw_valid  = slv_req_i.aw_valid & hs_en;

  assign mst_req_o.ar.id     = slv_req_i.ar.id;
  assign mst_req_o.ar.addr   = mst_ar_addr_i;
  assign mst_req_o.ar.len    = slv_req_i.ar.len;
  assign mst_req_o.ar.size   = slv_req_i.ar.size;
  assign mst_req_o.ar.burst  = slv_req_i.ar.burst;
  assign mst_req_o.ar.lock   = slv_req_i.ar.lock;
  assign mst_req_o.ar.cache  = slv_req_i.ar.cache;
  assign mst_req_o.ar.prot   = slv_req_i.ar.prot;
  assign mst_req_o.ar.qos    = slv_req_i.ar.qos;
  assign mst_req_o.ar.region = slv_req_i.ar.region;
  assign mst_req_o.ar.user   = slv_req_i.ar.user;
  assign mst_req_o.ar_valid  = slv_req_i.ar_valid & hs_en;

  assign mst_req_o.w         = slv_req_i.w;
  assign mst_req_o.w_valid   = slv_req_i.w_valid & hs_en;
  assign mst_req_o.b_ready   = slv_req_i.b_ready & hs_en;
  assign mst_req_o.r_ready   = slv_req_i.r_ready & hs_en;

  // Valids are never derived from readies here, so no combinational loop is introduced.
  assign slv_resp_o.aw_ready = mst_resp_i.aw_ready & hs_en;
  assign slv_resp_o.ar_ready = mst_resp_i.ar_ready & hs_en;
  assign slv_resp_o.w_ready  = mst_resp_i.w_ready & hs_en;
  assign slv_resp_o.b        = mst_resp_i.b;
  assign slv_resp_o.b_valid  = mst_resp_i.b_valid & hs_en;
  assign slv_resp_o.r        = mst_resp_i.r;
  assign slv_resp_o.r_valid  = mst_resp_i.r_valid & hs_en;

endmodule

// File: tb/tb_axi_modify_address.sv
// Directed bench for axi_modify_address: remap, stall, transparency, reset gating, random sweep.
module tb_axi_modify_address;
  import axi_modify_address_pkg::*;

  logic      clk;
  logic      rst;
  slv_req_t  slv_req;
  resp_t     slv_resp;
  mst_addr_t aw_addr;
  mst_addr_t ar_addr;
  mst_req_t  mst_req;
  resp_t     mst_resp;

  int vectors;
  int miscompares;

  axi_modify_address dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .slv_req_i    (slv_req),
    .slv_resp_o   (slv_resp),
    .mst_aw_addr_i(aw_addr),
    .mst_ar_addr_i(ar_addr),
    .mst_req_o    (mst_req),
    .mst_resp_i   (mst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: upstream request with the address fields replaced and handshakes gated by reset.
  function automatic mst_req_t ref_req(input slv_req_t s, input mst_addr_t awa,
                                       input mst_addr_t ara, input logic r);
    mst_req_t m;
    m.aw.id = s.aw.id;         m.aw.addr = awa;           m.aw.len = s.aw.len;
    m.aw.size = s.aw.size;     m.aw.burst = s.aw.burst;   m.aw.lock = s.aw.lock;
    m.aw.cache = s.aw.cache;   m.aw.prot = s.aw.prot;     m.aw.qos = s.aw.qos;
    m.aw.region = s.aw.region; m.aw.atop = s.aw.atop;     m.aw.user = s.aw.user;
    m.ar.id = s.ar.id;         m.ar.addr = ara;           m.ar.len = s.ar.len;
    m.ar.size = s.ar.size;     m.ar.burst = s.ar.burst;   m.ar.lock = s.ar.lock;
    m.ar.cache = s.ar.cache;   m.ar.prot = s.ar.prot;     m.ar.qos = s.ar.qos;
    m.ar.region = s.ar.region; m.ar.user = s.ar.user;
    m.w = s.w;
    m.aw_valid = s.aw_valid & ~r;
    m.w_valid  = s.w_valid & ~r;
    m.ar_valid = s.ar_valid & ~r;
    m.b_ready  = s.b_ready & ~r;
    m.r_ready  = s.r_ready & ~r;
    return m;
  endfunction

  function automatic resp_t ref_resp(input resp_t m, input logic r);
    resp_t s;
    s = m;
    s.aw_ready = m.aw_ready & ~r;
    s.ar_ready = m.ar_ready & ~r;
    s.w_ready  = m.w_ready & ~r;
    s.b_valid  = m.b_valid & ~r;
    s.r_valid  = m.r_valid & ~r;
    return s;
  endfunction

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [$bits(slv_req_t)-1:0] rs;
    logic [$bits(resp_t)-1:0]    rm;
    vectors     = 0;
    miscompares = 0;
    slv_req  = '0;
    mst_resp = '0;
    aw_addr  = '0;
    ar_addr  = '0;

    // Reset with every valid and ready offered from both neighbours.
    rst = 1'b1;
    slv_req.aw_valid = 1'b1; slv_req.w_valid = 1'b1; slv_req.ar_valid = 1'b1;
    slv_req.b_ready  = 1'b1; slv_req.r_ready = 1'b1;
    mst_resp.aw_ready = 1'b1; mst_resp.w_ready = 1'b1; mst_resp.ar_ready = 1'b1;
    mst_resp.b_valid  = 1'b1; mst_resp.r_valid = 1'b1;
    slv_req.w.data = 64'h0123_4567_89AB_CDEF;
    aw_addr = 48'hAAAA_5555_0001;
    settle();
    check("rst_aw_valid", 512'(mst_req.aw_valid), 512'(1'b0));
    check("rst_aw_ready", 512'(slv_resp.aw_ready), 512'(1'b0));
    check("rst_mst_hs", 512'({mst_req.w_valid, mst_req.ar_valid, mst_req.b_ready, mst_req.r_ready}), 512'(4'h0));
    check("rst_slv_hs", 512'({slv_resp.w_ready, slv_resp.ar_ready, slv_resp.b_valid, slv_resp.r_valid}), 512'(4'h0));
    check("rst_w_data", 512'(mst_req.w.data), 512'(64'h0123_4567_89AB_CDEF));
    check("rst_aw_addr", 512'(mst_req.aw.addr), 512'(48'hAAAA_5555_0001));

    @(negedge clk);
    rst = 1'b0;
    settle();
    check("post_rst_aw_valid", 512'(mst_req.aw_valid), 512'(1'b1));
    check("post_rst_aw_ready", 512'(slv_resp.aw_ready), 512'(1'b1));

    // Page remap on AW.
    @(negedge clk);
    slv_req  = '0;
    mst_resp = '0;
    slv_req.aw.addr  = 32'h0000_1ABC;
    slv_req.aw.id    = 3'd5;
    slv_req.aw.len   = 8'd7;
    slv_req.aw.size  = 3'd3;
    slv_req.aw.burst = BURST_INCR;
    slv_req.aw.cache = 4'hA;
    slv_req.aw.atop  = 6'h21;
    slv_req.aw.user  = 2'd2;
    slv_req.aw_valid = 1'b1;
    mst_resp.aw_ready = 1'b1;
    aw_addr = 48'h1234_5678_9ABC;
    #1;
    check("aw_addr", 512'(mst_req.aw.addr), 512'(48'h1234_5678_9ABC));
    check("aw_id", 512'(mst_req.aw.id), 512'(3'd5));
    check("aw_len", 512'(mst_req.aw.len), 512'(8'd7));
    check("aw_user", 512'(mst_req.aw.user), 512'(2'd2));
    check("aw_atop_cache", 512'({mst_req.aw.atop, mst_req.aw.cache, mst_req.aw.burst}), 512'({6'h21, 4'hA, 2'b01}));
    check("aw_hs", 512'({mst_req.aw_valid, slv_resp.aw_ready}), 512'(2'b11));

    // AR remap held against a stalled downstream.
    @(negedge clk);
    slv_req  = '0;
    mst_resp = '0;
    slv_req.ar.addr  = 32'h8000_0FFF;
    slv_req.ar.id    = 3'd2;
    slv_req.ar.len   = 8'd15;
    slv_req.ar.prot  = 3'd6;
    slv_req.ar_valid = 1'b1;
    ar_addr = 48'hFFFF_FFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("ar_stall_addr", 512'(mst_req.ar.addr), 512'(48'hFFFF_FFFF_FFFF));
      check("ar_stall_hs", 512'({mst_req.ar_valid, slv_resp.ar_ready}), 512'(2'b10));
      check("ar_stall_fields", 512'({mst_req.ar.id, mst_req.ar.len, mst_req.ar.prot}), 512'({3'd2, 8'd15, 3'd6}));
      @(negedge clk);
    end
    mst_resp.ar_ready = 1'b1;
    #1;
    check("ar_release_hs", 512'({mst_req.ar_valid, slv_resp.ar_ready}), 512'(2'b11));
    check("ar_release_addr", 512'(mst_req.ar.addr), 512'(48'hFFFF_FFFF_FFFF));

    // W, B and R transparency.
    @(negedge clk);
    slv_req  = '0;
    mst_resp = '0;
    slv_req.w.data = 64'hDEAD_BEEF_CAFE_F00D;
    slv_req.w.strb = 8'hFF;
    slv_req.w.last = 1'b1;
    slv_req.w.user = 2'd1;
    slv_req.w_valid = 1'b1;
    slv_req.b_ready = 1'b1;
    mst_resp.w_ready = 1'b1;
    mst_resp.b.id    = 3'd5;
    mst_resp.b.resp  = RESP_SLVERR;
    mst_resp.b.user  = 2'd3;
    mst_resp.b_valid = 1'b1;
    mst_resp.r.id    = 3'd6;
    mst_resp.r.data  = 64'h5A5A_0F0F_1234_8765;
    mst_resp.r.resp  = RESP_DECERR;
    mst_resp.r.last  = 1'b1;
    mst_resp.r_valid = 1'b1;
    slv_req.r_ready  = 1'b1;
    #1;
    check("w_chan", 512'(mst_req.w), 512'({64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b1, 2'd1}));
    check("w_hs", 512'({mst_req.w_valid, slv_resp.w_ready}), 512'(2'b11));
    check("b_chan", 512'(slv_resp.b), 512'({3'd5, 2'b10, 2'd3}));
    check("b_hs", 512'({slv_resp.b_valid, mst_req.b_ready}), 512'(2'b11));
    check("r_chan", 512'(slv_resp.r), 512'({3'd6, 64'h5A5A_0F0F_1234_8765, 2'b11, 1'b1, 2'd0}));
    check("r_hs", 512'({slv_resp.r_valid, mst_req.r_ready}), 512'(2'b11));

    // Simultaneous AW and AR, each with its own address.
    @(negedge clk);
    slv_req  = '0;
    mst_resp = '0;
    slv_req.aw.addr = 32'h0000_2000; slv_req.aw.id = 3'd1; slv_req.aw_valid = 1'b1;
    slv_req.ar.addr = 32'h0000_2000; slv_req.ar.id = 3'd4; slv_req.ar_valid = 1'b1;
    mst_resp.aw_ready = 1'b1;
    mst_resp.ar_ready = 1'b1;
    aw_addr = 48'h0000_0BAD_1000;
    ar_addr = 48'h7777_0000_2000;
    #1;
    check("dual_aw_addr", 512'(mst_req.aw.addr), 512'(48'h0000_0BAD_1000));
    check("dual_ar_addr", 512'(mst_req.ar.addr), 512'(48'h7777_0000_2000));
    check("dual_hs", 512'({mst_req.aw_valid, slv_resp.aw_ready, mst_req.ar_valid, slv_resp.ar_ready}), 512'(4'hF));

    // Random sweep with occasional reset pulses.
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      for (int k = 0; k < $bits(slv_req_t); k++) rs[k] = 1'($urandom_range(0, 1));
      for (int k = 0; k < $bits(resp_t); k++) rm[k] = 1'($urandom_range(0, 1));
      slv_req  = slv_req_t'(rs);
      mst_resp = resp_t'(rm);
      aw_addr  = mst_addr_t'({$urandom, $urandom});
      ar_addr  = mst_addr_t'({$urandom, $urandom});
      rst      = ($urandom_range(0, 9) == 0);
      #1;
      check("rand_mst_req", 512'(mst_req), 512'(ref_req(slv_req, aw_addr, ar_addr, rst)));
      check("rand_slv_resp", 512'(slv_resp), 512'(ref_resp(mst_resp, rst)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
